// File: rtl/goal_flag_ctrl.sv
// Goal flag controller: raises the flag after the player lands on the goal tile,
// runs a timed celebration, then holds with a waving flag until restart.
module goal_flag_ctrl #(
  parameter int FLAG_TILE          = 9,
  parameter int Y_LOWERED          = 134,
  parameter int Y_RAISED           = 80,
  parameter int RAISE_STEP_FRAMES  = 2,
  parameter int WAVE_PERIOD_FRAMES = 8,
  parameter int CELEBRATE_FRAMES   = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [3:0] player_tile,
  input  logic       player_move_done,
  input  logic       game_restart,
  output logic [9:0] flag_y_top,
  output logic [1:0] wave_phase,
  output logic       goal_reached,
  output logic       celebrate
);

  localparam int SW = (RAISE_STEP_FRAMES  > 1) ? $clog2(RAISE_STEP_FRAMES)  : 1;
  localparam int CW = (CELEBRATE_FRAMES   > 1) ? $clog2(CELEBRATE_FRAMES)   : 1;
  localparam int WW = (WAVE_PERIOD_FRAMES > 1) ? $clog2(WAVE_PERIOD_FRAMES) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(RAISE_STEP_FRAMES - 1);
  localparam logic [CW-1:0] CEL_LAST  = CW'(CELEBRATE_FRAMES - 1);
  localparam logic [WW-1:0] WAVE_LAST = WW'(WAVE_PERIOD_FRAMES - 1);
  localparam logic [9:0]    Y_LOW     = 10'(Y_LOWERED);
  localparam logic [9:0]    Y_UP      = 10'(Y_RAISED);
  localparam logic [3:0]    GOAL_TILE = 4'(FLAG_TILE);

  typedef enum logic [1:0] {IDLE, RAISE, CELEBRATE, HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_flag_y, w_flag_y_nxt, w_flag_y_dec;
  logic [SW-1:0] r_step_cnt, w_step_cnt_nxt;
  logic [CW-1:0] r_cel_cnt, w_cel_cnt_nxt;
  logic [WW-1:0] r_wave_cnt, w_wave_cnt_nxt;
  logic [1:0]    r_wave_phase, w_wave_phase_nxt;
  logic          r_goal, r_celebrate;

  assign w_flag_y_dec = r_flag_y - 10'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_flag_y     <= Y_LOW;
      r_step_cnt   <= '0;
      r_cel_cnt    <= '0;
      r_wave_cnt   <= '0;
      r_wave_phase <= '0;
      r_goal       <= 1'b0;
      r_celebrate  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flag_y     <= w_flag_y_nxt;
      r_step_cnt   <= w_step_cnt_nxt;
      r_cel_cnt    <= w_cel_cnt_nxt;
      r_wave_cnt   <= w_wave_cnt_nxt;
      r_wave_phase <= w_wave_phase_nxt;
      r_goal       <= (w_state_nxt != IDLE);
      r_celebrate  <= (w_state_nxt == CELEBRATE);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_flag_y_nxt     = r_flag_y;
    w_step_cnt_nxt   = r_step_cnt;
    w_cel_cnt_nxt    = r_cel_cnt;
    w_wave_cnt_nxt   = r_wave_cnt;
    w_wave_phase_nxt = r_wave_phase;

    if (game_restart) begin
      w_state_nxt      = IDLE;
      w_flag_y_nxt     = Y_LOW;
      w_step_cnt_nxt   = '0;
      w_cel_cnt_nxt    = '0;
      w_wave_cnt_nxt   = '0;
      w_wave_phase_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_wave_cnt_nxt   = '0;
          w_wave_phase_nxt = '0;
          // A frame_tick arriving with the goal move is deliberately not counted.
          if (player_move_done && (player_tile == GOAL_TILE)) begin
            w_state_nxt    = RAISE;
            w_step_cnt_nxt = '0;
          end
        end
        RAISE: begin
          w_wave_cnt_nxt   = '0;
          w_wave_phase_nxt = '0;
          if (frame_tick) begin
            if (r_flag_y <= Y_UP) begin
              w_state_nxt   = CELEBRATE;
              w_cel_cnt_nxt = '0;
            end else if (r_step_cnt == STEP_LAST) begin
              w_step_cnt_nxt = '0;
              w_flag_y_nxt   = w_flag_y_dec;
              if (w_flag_y_dec == Y_UP) begin
                w_state_nxt   = CELEBRATE;
                w_cel_cnt_nxt = '0;
              end
            end else begin
              w_step_cnt_nxt = r_step_cnt + 1'b1;
            end
          end
        end
        CELEBRATE, HOLD: begin
          if (frame_tick) begin
            if (r_wave_cnt == WAVE_LAST) begin
              w_wave_cnt_nxt   = '0;
              w_wave_phase_nxt = r_wave_phase + 2'd1;
            end else begin
              w_wave_cnt_nxt = r_wave_cnt + 1'b1;
            end
            if (r_state == CELEBRATE) begin
              if (r_cel_cnt == CEL_LAST) begin
                w_state_nxt   = HOLD;
                w_cel_cnt_nxt = '0;
              end else begin
                w_cel_cnt_nxt = r_cel_cnt + 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign flag_y_top   = r_flag_y;
  assign wave_phase   = r_wave_phase;
  assign goal_reached = r_goal;
  assign celebrate    = r_celebrate;

endmodule

// File: tb/tb_goal_flag_ctrl.sv
// Scoreboard bench for goal_flag_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_goal_flag_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [3:0] player_tile;
  logic       player_move_done;
  logic       game_restart;
  logic [9:0] flag_y_top;
  logic [1:0] wave_phase;
  logic       goal_reached;
  logic       celebrate;

  typedef struct packed {
    logic [9:0] y;
    logic [1:0] ph;
    logic       g;
    logic       c;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  goal_flag_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_tick       (frame_tick),
    .player_tile      (player_tile),
    .player_move_done (player_move_done),
    .game_restart     (game_restart),
    .flag_y_top       (flag_y_top),
    .wave_phase       (wave_phase),
    .goal_reached     (goal_reached),
    .celebrate        (celebrate)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs starting just after a rising edge; pulses drop afterwards.
  task automatic applyStimulus(input logic ft, input logic md, input logic [3:0] tile,
                               input logic rs);
    frame_tick       = ft;
    player_move_done = md;
    player_tile      = tile;
    game_restart     = rs;
    @(posedge clk);
    #1;
    frame_tick       = 1'b0;
    player_move_done = 1'b0;
    game_restart     = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [9:0] y, input logic [1:0] ph,
                             input logic g, input logic c);
    exp_t e;
    e.y = y; e.ph = ph; e.g = g; e.c = c;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Monitor: on each falling edge, compare every pending expectation against the DUT.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t  e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      testsRun++;
      if (flag_y_top !== e.y || wave_phase !== e.ph || goal_reached !== e.g ||
          celebrate !== e.c) begin
        testsFailed++;
        $display("[TB] FAIL %s: got y=%0d ph=%0d goal=%0b cel=%0b, expected y=%0d ph=%0d goal=%0b cel=%0b",
                 n, flag_y_top, wave_phase, goal_reached, celebrate, e.y, e.ph, e.g, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    player_tile = 4'd0;
    player_move_done = 1'b0;
    game_restart = 1'b0;
    checkOutput("reset_values", 10'd134, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Non-goal tiles are ignored in IDLE.
    applyStimulus(1'b0, 1'b1, 4'd8, 1'b0);
    checkOutput("tile8_ignored", 10'd134, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd10, 1'b0);
    checkOutput("tile10_ignored", 10'd134, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b0);
    checkOutput("tile15_ignored", 10'd134, 2'd0, 1'b0, 1'b0);

    // Goal move together with a frame_tick: that tick must not count.
    applyStimulus(1'b1, 1'b1, 4'd9, 1'b0);
    checkOutput("goal_enter_raise", 10'd134, 2'd0, 1'b1, 1'b0);
    ticks(1);
    checkOutput("raise_tick1_no_dec", 10'd134, 2'd0, 1'b1, 1'b0);
    ticks(1);
    checkOutput("raise_tick2_first_dec", 10'd133, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("no_change_without_tick", 10'd133, 2'd0, 1'b1, 1'b0);
    ticks(105);
    checkOutput("raise_tick107", 10'd81, 2'd0, 1'b1, 1'b0);
    ticks(1);
    checkOutput("raise_tick108_top", 10'd80, 2'd0, 1'b1, 1'b1);

    // Celebration window and wave sequence.
    for (int i = 1; i <= 120; i++) begin
      ticks(1);
      case (i)
        7:   checkOutput("wave_t7",   10'd80, 2'd0, 1'b1, 1'b1);
        8:   checkOutput("wave_t8",   10'd80, 2'd1, 1'b1, 1'b1);
        16:  checkOutput("wave_t16",  10'd80, 2'd2, 1'b1, 1'b1);
        24:  checkOutput("wave_t24",  10'd80, 2'd3, 1'b1, 1'b1);
        32:  checkOutput("wave_t32_wrap", 10'd80, 2'd0, 1'b1, 1'b1);
        119: checkOutput("cel_t119",  10'd80, 2'd2, 1'b1, 1'b1);
        120: checkOutput("cel_t120_hold", 10'd80, 2'd3, 1'b1, 1'b0);
        default: ;
      endcase
    end

    // HOLD ignores moves; restart with a tick goes straight to IDLE without a phase step.
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
    checkOutput("hold_ignores_move", 10'd80, 2'd3, 1'b1, 1'b0);
    ticks(15);
    checkOutput("hold_t135", 10'd80, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("restart_with_tick", 10'd134, 2'd0, 1'b0, 1'b0);
    ticks(1);
    checkOutput("idle_after_restart", 10'd134, 2'd0, 1'b0, 1'b0);

    // Restart mid-raise; a move in RAISE must not reset the step counter.
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
    ticks(67);
    checkOutput("raise_t67", 10'd101, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
    checkOutput("raise_ignores_move", 10'd101, 2'd0, 1'b1, 1'b0);
    ticks(1);
    checkOutput("raise_reach_100", 10'd100, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("restart_mid_raise", 10'd134, 2'd0, 1'b0, 1'b0);

    // Async reset between edges during CELEBRATE.
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
    ticks(108);
    checkOutput("celebrate_again", 10'd80, 2'd0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    checkOutput("async_reset_immediate", 10'd134, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
    checkOutput("first_edge_after_reset", 10'd134, 2'd0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
